vbus_initiator: RTL and testbench

VBUS_INITIATOR -- requirements
Module: vbus_initiator

---
 rtl/vbus_initiator_pkg.sv | 13 +
 rtl/vbus_timeout_ctr.sv | 29 ++
 rtl/vbus_initiator.sv | 133 +++++++++++++
 tb/tb_vbus_initiator.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vbus_initiator_pkg.sv
// Shared types and defaults for the vbus initiator and its timeout counter.
package vbus_initiator_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_TIMEOUT   = 256;
   localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/vbus_timeout_ctr.sv
// Counts consecutive enabled cycles from 1; expired flags the cycle whose number equals LIMIT.
module vbus_timeout_ctr
   import vbus_initiator_pkg::*;
#(
   parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic nreset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [15:0] count;

   // count holds the number of enabled cycles already completed, so cycle k sees k-1
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         count <= 16'd0;
      end else if (clear) begin
         count <= 16'd0;
      end else if (enable && !expired) begin
         count <= count + 16'd1;
      end
   end

   assign expired = enable && (count == 16'(LIMIT - 1));

endmodule

// File: rtl/vbus_initiator.sv
// Single-outstanding command/response bridge onto the simulation-control bus.
// Optional strobe timeout is built only when VBUS_INITIATOR_TIMEOUT_EN is defined.
module vbus_initiator
   import vbus_initiator_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
   parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] addr,
   output logic [31:0] dataout,
   output logic        we,
   input  logic        wrack,
   output logic        rd,
   input  logic        rdack,
   input  logic [31:0] datain
);

   state_t      state;
   state_t      next_state;
   logic        started;
   logic        is_write;
   logic        accept;
   logic        ack_hit;
   logic        timeout_hit;
   logic [31:0] addr_q;
   logic [31:0] dataout_q;
   logic [31:0] rdata_q;

   // started keeps cmd_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state   <= IDLE;
         started <= 1'b0;
      end else begin
         state   <= next_state;
         started <= 1'b1;
      end
   end

   assign accept  = cmd_valid && cmd_ready;
   assign ack_hit = (state == ACCESS) && (is_write ? wrack : rdack);

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = ACCESS;
         ACCESS:  if (ack_hit || timeout_hit) next_state = RESP;
         RESP:    if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state == IDLE) && started;
      rsp_valid = (state == RESP);
      we        = (state == ACCESS) && is_write;
      rd        = (state == ACCESS) && !is_write;
   end

   // Ack wins over timeout; write responses always carry zero data
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         is_write  <= 1'b0;
         addr_q    <= 32'd0;
         dataout_q <= 32'd0;
         rdata_q   <= 32'd0;
      end else begin
         if (accept) begin
            is_write  <= cmd_we;
            addr_q    <= cmd_addr;
            dataout_q <= cmd_we ? cmd_wdata : 32'd0;
         end
         if (ack_hit) begin
            rdata_q <= is_write ? 32'd0 : datain;
         end else if (timeout_hit) begin
            rdata_q <= is_write ? 32'd0 : ERR_RDATA;
         end
      end
   end

   assign addr      = addr_q;
   assign dataout   = dataout_q;
   assign rsp_rdata = rdata_q;

`ifdef VBUS_INITIATOR_TIMEOUT_EN
   logic expired;
   logic err_q;
   logic ctr_clear;
   logic ctr_enable;

   assign ctr_clear  = (state != ACCESS);
   assign ctr_enable = (state == ACCESS);

   vbus_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .nreset  (nreset),
      .clear   (ctr_clear),
      .enable  (ctr_enable),
      .expired (expired)
   );

   assign timeout_hit = (state == ACCESS) && expired;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         err_q <= 1'b0;
      end else if (ack_hit) begin
         err_q <= 1'b0;
      end else if (timeout_hit) begin
         err_q <= 1'b1;
      end
   end

   assign rsp_err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_vbus_initiator.sv
// Directed bench for vbus_initiator; the timeout steps run when VBUS_INITIATOR_TIMEOUT_EN is defined.
module tb_vbus_initiator;

   logic        clk;
   logic        nreset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] addr;
   logic [31:0] dataout;
   logic        we;
   logic        wrack;
   logic        rd;
   logic        rdack;
   logic [31:0] datain;
   logic        tie_ack;
   logic        wrack_drv;
   logic        rdack_drv;

   int vectors;
   int miscompares;
   int strobe_count;

   vbus_initiator #(
      .TIMEOUT_CYCLES (8),
      .ERR_RDATA      (32'hDEADBEEF)
   ) dut (
      .clk       (clk),
      .nreset    (nreset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .addr      (addr),
      .dataout   (dataout),
      .we        (we),
      .wrack     (wrack),
      .rd        (rd),
      .rdack     (rdack),
      .datain    (datain)
   );

   // Zero-wait target: acks follow the strobes combinationally when tie_ack is set
   assign wrack = tie_ack ? we : wrack_drv;
   assign rdack = tie_ack ? rd : rdack_drv;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic valid, input logic write,
                                input logic [31:0] a, input logic [31:0] d);
      cmd_valid = valid;
      cmd_we    = write;
      cmd_addr  = a;
      cmd_wdata = d;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      nreset      = 1'b0;
      tie_ack     = 1'b0;
      wrack_drv   = 1'b0;
      rdack_drv   = 1'b0;
      datain      = 32'd0;
      rsp_ready   = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

      tick();
      checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
      checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      checkOutput("rst_addr", addr, 32'd0);
      checkOutput("rst_dataout", dataout, 32'd0);
      checkOutput("rst_we_rd", {30'd0, we, rd}, 32'd0);
      nreset = 1'b1;
      tick();
      checkOutput("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      $display("[TB] zero-wait write");
      tie_ack = 1'b1;
      applyStimulus(1'b1, 1'b1, 32'h0000_0008, 32'h0000_0001);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
      checkOutput("zw_we_high", {31'd0, we}, 32'd1);
      checkOutput("zw_rd_low", {31'd0, rd}, 32'd0);
      checkOutput("zw_addr", addr, 32'h0000_0008);
      checkOutput("zw_dataout", dataout, 32'h0000_0001);
      checkOutput("zw_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      checkOutput("zw_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
      checkOutput("zw_we_dropped", {31'd0, we}, 32'd0);
      checkOutput("zw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("zw_rsp_err", {31'd0, rsp_err}, 32'd0);
      checkOutput("zw_rsp_rdata", rsp_rdata, 32'd0);
      tick();
      checkOutput("zw_rsp_done", {31'd0, rsp_valid}, 32'd0);
      checkOutput("zw_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
      checkOutput("zw_addr_held", addr, 32'h0000_0008);

      $display("[TB] wait-stated read");
      tie_ack = 1'b0;
      strobe_count = 0;
      applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF);
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 1) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
         checkOutput("ws_rd_high", {31'd0, rd}, 32'd1);
         checkOutput("ws_no_rsp", {31'd0, rsp_valid}, 32'd0);
         if (rd) strobe_count++;
         if (i == 6) begin
            rdack_drv = 1'b1;
            datain    = 32'h0000_2710;
         end
      end
      tick();
      rdack_drv = 1'b0;
      datain    = 32'd0;
      checkOutput("ws_rd_cycles", strobe_count, 32'd6);
      checkOutput("ws_rd_dropped", {31'd0, rd}, 32'd0);
      checkOutput("ws_dataout_zero", dataout, 32'd0);
      checkOutput("ws_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("ws_rsp_rdata", rsp_rdata, 32'h0000_2710);
      tick();
      checkOutput("ws_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

      $display("[TB] response back-pressure");
      tie_ack   = 1'b1;
      rsp_ready = 1'b0;
      datain    = 32'hCAFE_0001;
      applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'd0);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0077);
      tick();
      datain = 32'h0BAD_0BAD;
      for (int r = 1; r <= 4; r++) begin
         checkOutput("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         checkOutput("bp_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
         checkOutput("bp_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
         checkOutput("bp_no_strobe", {30'd0, we, rd}, 32'd0);
         tick();
      end
      checkOutput("bp_still_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_addr_held", addr, 32'h0000_0020);
      rsp_ready = 1'b1;
      tick();
      checkOutput("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
      checkOutput("bp_idle_no_rsp", {31'd0, rsp_valid}, 32'd0);
      checkOutput("bp_idle_no_we", {31'd0, we}, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
      checkOutput("bp_next_we", {31'd0, we}, 32'd1);
      checkOutput("bp_next_addr", addr, 32'h0000_0040);
      checkOutput("bp_next_dataout", dataout, 32'h0000_0077);
      tick();
      checkOutput("bp_next_rsp", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_next_rdata", rsp_rdata, 32'd0);
      tick();

      $display("[TB] stray acknowledges");
      tie_ack   = 1'b0;
      wrack_drv = 1'b1;
      rdack_drv = 1'b1;
      tick();
      checkOutput("stray_idle_ready", {31'd0, cmd_ready}, 32'd1);
      checkOutput("stray_idle_no_rsp", {31'd0, rsp_valid}, 32'd0);
      checkOutput("stray_idle_no_strobe", {30'd0, we, rd}, 32'd0);
      wrack_drv = 1'b0;
      applyStimulus(1'b1, 1'b1, 32'h0000_0050, 32'h0000_0005);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
      for (int k = 1; k <= 3; k++) begin
         checkOutput("stray_we_held", {31'd0, we}, 32'd1);
         checkOutput("stray_no_rsp", {31'd0, rsp_valid}, 32'd0);
         tick();
      end
      checkOutput("stray_we_still", {31'd0, we}, 32'd1);
      rdack_drv = 1'b0;
      wrack_drv = 1'b1;
      tick();
      wrack_drv = 1'b0;
      checkOutput("stray_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("stray_rsp_err", {31'd0, rsp_err}, 32'd0);
      tick();

      $display("[TB] reset during access");
      applyStimulus(1'b1, 1'b0, 32'h0000_0060, 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
      checkOutput("mid_rd_high", {31'd0, rd}, 32'd1);
      #2;
      nreset = 1'b0;
      #1;
      checkOutput("mid_rst_strobes", {30'd0, we, rd}, 32'd0);
      checkOutput("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      checkOutput("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("mid_rst_addr", addr, 32'd0);
      tick();
      nreset = 1'b1;
      tick();
      checkOutput("mid_after_ready", {31'd0, cmd_ready}, 32'd1);
      checkOutput("mid_after_no_rsp", {31'd0, rsp_valid}, 32'd0);
      tie_ack = 1'b1;
      applyStimulus(1'b1, 1'b1, 32'h0000_0064, 32'h0000_0009);
      tick();
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
      checkOutput("mid_next_we", {31'd0, we}, 32'd1);
      checkOutput("mid_next_addr", addr, 32'h0000_0064);
      tick();
      checkOutput("mid_next_rsp", {31'd0, rsp_valid}, 32'd1);
      checkOutput("mid_next_err", {31'd0, rsp_err}, 32'd0);
      tick();
      tie_ack = 1'b0;

`ifdef VBUS_INITIATOR_TIMEOUT_EN
      $display("[TB] read timeout");
      strobe_count = 0;
      applyStimulus(1'b1, 1'b0, 32'h0000_0070, 32'd0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 1) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
         checkOutput("to_rd_high", {31'd0, rd}, 32'd1);
         if (rd) strobe_count++;
      end
      tick();
      checkOutput("to_rd_cycles", strobe_count, 32'd8);
      checkOutput("to_rd_dropped", {31'd0, rd}, 32'd0);
      checkOutput("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("to_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      checkOutput("to_rsp_err", {31'd0, rsp_err}, 32'd1);
      tick();
      checkOutput("to_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

      applyStimulus(1'b1, 1'b0, 32'h0000_0074, 32'd0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 1) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
         checkOutput("tack_rd_high", {31'd0, rd}, 32'd1);
         if (i == 8) begin
            rdack_drv = 1'b1;
            datain    = 32'h0000_0055;
         end
      end
      tick();
      rdack_drv = 1'b0;
      checkOutput("tack_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("tack_rsp_rdata", rsp_rdata, 32'h0000_0055);
      checkOutput("tack_rsp_err", {31'd0, rsp_err}, 32'd0);
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
